// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: opcode decode, counter
// initial/threshold values and miss-policy encodings.
package branch_predictor_pkg;

  // RISC-V conditional branch (B-type) major opcode
  localparam logic [6:0] B_OPCODE = 7'b1100011;

  // Prediction used when a B-type lookup misses the table
  localparam int MISS_NOT_TAKEN = 0;
  localparam int MISS_BTFN      = 1;

  // Weakly-taken value: the smallest counter value whose MSB is set
  function automatic int cnt_weak_taken(input int w);
    return 1 << (w - 1);
  endfunction

  // Weakly-not-taken value: one below the taken threshold; also the reset value
  function automatic int cnt_weak_not_taken(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle of the branch predictor. The master side is the
// pipeline (drives lookups and resolved outcomes), the slave side the predictor.
interface branch_predictor_if #(
  parameter int ADDR_W = 32
);
  logic              lookup_valid_i;
  logic [ADDR_W-1:0] lookup_pc_i;
  logic [31:0]       lookup_inst_i;
  logic              hold_i;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic              upd_mispredict_i;
  logic              flush_i;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic              pred_hit_o;
  logic [31:0]       stat_lookups_o;
  logic [31:0]       stat_mispred_o;

  modport master (
    output lookup_valid_i, lookup_pc_i, lookup_inst_i, hold_i,
           upd_valid_i, upd_pc_i, upd_taken_i, upd_mispredict_i, flush_i,
    input  pred_taken_o, pred_target_o, pred_hit_o,
           stat_lookups_o, stat_mispred_o
  );

  modport slave (
    input  lookup_valid_i, lookup_pc_i, lookup_inst_i, hold_i,
           upd_valid_i, upd_pc_i, upd_taken_i, upd_mispredict_i, flush_i,
    output pred_taken_o, pred_target_o, pred_hit_o,
           stat_lookups_o, stat_mispred_o
  );
endinterface

// File: rtl/bp_sat_cnt.sv
// Up/down saturating counter with parallel load; one per history entry.
module bp_sat_cnt
  import branch_predictor_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX  = '1;
  localparam logic [W-1:0] CNT_INIT = W'(cnt_weak_not_taken(W));

  // Load takes precedence; otherwise step toward taken/not-taken and stick at the ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_INIT;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fully-associative branch history table with saturating counters,
// round-robin replacement and free-running lookup/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES     = 8,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 2,
  parameter int MISS_POLICY = 0
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_TAKEN     = CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_NOT_TAKEN = CNT_W'(cnt_weak_not_taken(CNT_W));
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(ENTRIES - 1);

  logic [ENTRIES-1:0] valid;
  logic [ADDR_W-1:0]  tag [ENTRIES];
  logic [CNT_W-1:0]   cnt [ENTRIES];
  logic [IDX_W-1:0]   rp;

  logic               is_b;
  logic [12:0]        imm13;
  logic [ADDR_W-1:0]  imm_b;
  logic [ENTRIES-1:0] lk_match;
  logic [ENTRIES-1:0] up_match;
  logic [IDX_W-1:0]   lk_idx;
  logic               lk_any;
  logic               up_hit;
  logic               do_update;
  logic               do_alloc;
  logic [ENTRIES-1:0] ent_load;
  logic [ENTRIES-1:0] ent_inc;
  logic [ENTRIES-1:0] ent_dec;
  logic [CNT_W-1:0]   alloc_val;
  logic               count_lookup;
  logic               count_mispred;
  logic [31:0]        stat_lookups;
  logic [31:0]        stat_mispred;

  // Decode the fetched word: B-type detection and sign-extended branch offset
  always_comb begin
    is_b  = (bp.lookup_inst_i[6:0] == B_OPCODE);
    imm13 = {bp.lookup_inst_i[31], bp.lookup_inst_i[7],
             bp.lookup_inst_i[30:25], bp.lookup_inst_i[11:8], 1'b0};
    imm_b = ADDR_W'($signed(imm13));
  end

  assign bp.pred_target_o = bp.lookup_pc_i + imm_b;

  // One-hot tag compare for both the lookup port and the update port
  always_comb begin
    lk_match = '0;
    up_match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_match[i] = valid[i] && (tag[i] == bp.lookup_pc_i);
      up_match[i] = valid[i] && (tag[i] == bp.upd_pc_i);
    end
  end

  // OR-based binary encoder; allocation only on miss keeps the match vector one-hot
  always_comb begin
    lk_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (lk_match[i]) begin
        lk_idx = lk_idx | IDX_W'(i);
      end
    end
  end

  assign lk_any = |lk_match;
  assign up_hit = |up_match;

  // Prediction from pre-update table state; misses fall back to the static policy
  always_comb begin
    bp.pred_hit_o   = 1'b0;
    bp.pred_taken_o = 1'b0;
    if (bp.lookup_valid_i && is_b) begin
      bp.pred_hit_o = lk_any;
      if (lk_any) begin
        bp.pred_taken_o = cnt[lk_idx][CNT_W-1];
      end else if (MISS_POLICY == MISS_NOT_TAKEN) begin
        bp.pred_taken_o = 1'b0;
      end else begin
        bp.pred_taken_o = imm_b[ADDR_W-1];
      end
    end
  end

  // Per-entry counter controls; a flush suppresses any same-cycle update
  always_comb begin
    do_update = bp.upd_valid_i && !bp.flush_i;
    do_alloc  = do_update && !up_hit;
    alloc_val = bp.upd_taken_i ? CNT_TAKEN : CNT_NOT_TAKEN;
    ent_load  = '0;
    ent_inc   = '0;
    ent_dec   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ent_load[i] = do_alloc && (rp == IDX_W'(i));
      ent_inc[i]  = do_update && up_match[i] && bp.upd_taken_i;
      ent_dec[i]  = do_update && up_match[i] && !bp.upd_taken_i;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    bp_sat_cnt #(
      .W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ent_load[g]),
      .load_val (alloc_val),
      .inc      (ent_inc[g]),
      .dec      (ent_dec[g]),
      .cnt      (cnt[g])
    );
  end

  // Valid bits, tags and replacement pointer; flush drops every entry and rewinds rp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      rp    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i] <= '0;
      end
    end else if (bp.flush_i) begin
      valid <= '0;
      rp    <= '0;
    end else if (do_alloc) begin
      valid[rp] <= 1'b1;
      tag[rp]   <= bp.upd_pc_i;
      rp        <= (rp == IDX_LAST) ? '0 : rp + 1'b1;
    end
  end

  assign count_lookup  = bp.lookup_valid_i && is_b && !bp.hold_i;
  assign count_mispred = bp.upd_valid_i && bp.upd_mispredict_i;

  // Saturating statistics; intentionally untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      if (count_lookup && (stat_lookups != 32'hFFFF_FFFF)) begin
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (count_mispred && (stat_mispred != 32'hFFFF_FFFF)) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end

  assign bp.stat_lookups_o = stat_lookups;
  assign bp.stat_mispred_o = stat_mispred;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (8 entries, 2-bit counters, BTFN on miss).
module tb_branch_predictor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_lookups;
  logic [31:0] exp_mispred;

  branch_predictor_if #(.ADDR_W(32)) bus ();

  branch_predictor #(
    .ENTRIES     (8),
    .ADDR_W      (32),
    .CNT_W       (2),
    .MISS_POLICY (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a B-type (beq x1, x2) instruction word with the given byte offset
  function automatic logic [31:0] mk_b(input int imm);
    logic [12:0] v;
    v = imm[12:0];
    return {v[12], v[10:5], 5'd2, 5'd1, 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_update(input logic v, input logic [31:0] pc, input logic tk, input logic mp);
    bus.upd_valid_i      = v;
    bus.upd_pc_i         = pc;
    bus.upd_taken_i      = tk;
    bus.upd_mispredict_i = mp;
  endtask

  // One clock, returning to the falling edge where inputs change
  task automatic apply_stimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Combinational lookup probe that is never present at a clock edge
  task automatic probe(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                       input logic exp_hit, input logic exp_taken);
    bus.lookup_valid_i = 1'b1;
    bus.lookup_pc_i    = pc;
    bus.lookup_inst_i  = inst;
    #1;
    check_output({tag, "_hit"}, 32'(bus.pred_hit_o), 32'(exp_hit));
    check_output({tag, "_taken"}, 32'(bus.pred_taken_o), 32'(exp_taken));
    bus.lookup_valid_i = 1'b0;
  endtask

  task automatic update_cycle(input logic [31:0] pc, input logic tk, input logic mp);
    set_update(1'b1, pc, tk, mp);
    apply_stimulus();
    set_update(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_lookups = 0;
    exp_mispred = 0;
    rst_n = 1'b1;
    bus.lookup_valid_i = 1'b1;
    bus.lookup_pc_i    = 32'h100;
    bus.lookup_inst_i  = mk_b(-8);
    bus.hold_i         = 1'b0;
    bus.flush_i        = 1'b0;
    set_update(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset state: BTFN miss on a backward branch
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_hit", 32'(bus.pred_hit_o), 32'd0);
    check_output("rst_taken", 32'(bus.pred_taken_o), 32'd1);
    check_output("rst_target", bus.pred_target_o, 32'h0000_00F8);
    check_output("rst_lookups", bus.stat_lookups_o, 32'd0);
    check_output("rst_mispred", bus.stat_mispred_o, 32'd0);
    bus.lookup_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // One counted B-type lookup
    bus.lookup_valid_i = 1'b1;
    apply_stimulus();
    bus.lookup_valid_i = 1'b0;
    exp_lookups = 1;
    check_output("cnt_lookup", bus.stat_lookups_o, exp_lookups);

    // Allocate 0x100 taken; same-cycle lookup still sees the miss
    set_update(1'b1, 32'h100, 1'b1, 1'b1);
    probe("same_cycle", 32'h100, mk_b(-8), 1'b0, 1'b1);
    apply_stimulus();
    set_update(1'b0, 32'h0, 1'b0, 1'b0);
    exp_mispred = 1;
    check_output("mispred_1", bus.stat_mispred_o, exp_mispred);
    probe("alloc_taken", 32'h100, mk_b(16), 1'b1, 1'b1);

    // Four not-taken updates: 2 -> 1 -> 0 -> 0 -> 0
    repeat (4) update_cycle(32'h100, 1'b0, 1'b0);
    probe("sat_low", 32'h100, mk_b(-8), 1'b1, 1'b0);
    update_cycle(32'h100, 1'b1, 1'b0);
    probe("cnt_1", 32'h100, mk_b(-8), 1'b1, 1'b0);
    update_cycle(32'h100, 1'b1, 1'b0);
    probe("cnt_2", 32'h100, mk_b(16), 1'b1, 1'b1);
    check_output("lookups_idle", bus.stat_lookups_o, exp_lookups);

    // Flush invalidates the table
    bus.flush_i = 1'b1;
    apply_stimulus();
    bus.flush_i = 1'b0;
    probe("post_flush", 32'h100, mk_b(-8), 1'b0, 1'b1);

    // Nine allocations into eight entries: the ninth replaces entry 0
    for (int k = 0; k < 9; k++) update_cycle(32'h200 + 32'(4 * k), 1'b1, 1'b0);
    probe("evicted", 32'h200, mk_b(16), 1'b0, 1'b0);
    probe("pc2_hit", 32'h208, mk_b(16), 1'b1, 1'b1);
    probe("pc8_hit", 32'h220, mk_b(16), 1'b1, 1'b1);

    // Flush wins over a same-cycle allocating update
    bus.flush_i = 1'b1;
    set_update(1'b1, 32'h300, 1'b1, 1'b0);
    apply_stimulus();
    bus.flush_i = 1'b0;
    set_update(1'b0, 32'h0, 1'b0, 1'b0);
    probe("flush_upd", 32'h300, mk_b(16), 1'b0, 1'b0);
    probe("flush_old", 32'h208, mk_b(16), 1'b0, 1'b0);
    check_output("flush_rp", 32'(dut.rp), 32'd0);
    check_output("flush_lookups", bus.stat_lookups_o, exp_lookups);
    check_output("flush_mispred", bus.stat_mispred_o, exp_mispred);

    // A non-B word never hits, even on a valid tag
    update_cycle(32'h600, 1'b1, 1'b0);
    probe("non_b", 32'h600, 32'h0000_0013, 1'b0, 1'b0);
    probe("b_600", 32'h600, mk_b(16), 1'b1, 1'b1);

    // Held and non-B lookups are not counted; a plain B lookup is
    bus.lookup_valid_i = 1'b1;
    bus.lookup_pc_i    = 32'h600;
    bus.lookup_inst_i  = mk_b(16);
    bus.hold_i         = 1'b1;
    apply_stimulus();
    check_output("hold_lookups", bus.stat_lookups_o, exp_lookups);
    bus.hold_i         = 1'b0;
    bus.lookup_inst_i  = 32'h0000_0013;
    apply_stimulus();
    check_output("nonb_lookups", bus.stat_lookups_o, exp_lookups);
    bus.lookup_inst_i  = mk_b(16);
    apply_stimulus();
    bus.lookup_valid_i = 1'b0;
    exp_lookups = 2;
    check_output("b_lookups", bus.stat_lookups_o, exp_lookups);

    // Mispredict counter saturation from a preloaded value
    force dut.stat_mispred = 32'hFFFF_FFFE;
    #1;
    release dut.stat_mispred;
    #1;
    check_output("preload", bus.stat_mispred_o, 32'hFFFF_FFFE);
    update_cycle(32'h600, 1'b1, 1'b1);
    check_output("mispred_max", bus.stat_mispred_o, 32'hFFFF_FFFF);
    update_cycle(32'h600, 1'b1, 1'b1);
    check_output("mispred_sat", bus.stat_mispred_o, 32'hFFFF_FFFF);

    // Reset arriving during an update discards it and clears everything
    set_update(1'b1, 32'h700, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_lookups", bus.stat_lookups_o, 32'd0);
    check_output("midrst_mispred", bus.stat_mispred_o, 32'd0);
    @(negedge clk);
    set_update(1'b0, 32'h0, 1'b0, 1'b0);
    probe("midrst_700", 32'h700, mk_b(16), 1'b0, 1'b0);
    probe("midrst_600", 32'h600, mk_b(-8), 1'b0, 1'b1);
    rst_n = 1'b1;
    apply_stimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 8, number of history entries; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 32, instruction address width.
REQ-003 Parameter CNT_W, default 2, saturating-counter width; at least 1.
REQ-004 Parameter MISS_POLICY, default 0, prediction on table miss: 0 = not-taken, 1 = backward-taken/forward-not-taken (BTFN).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 lookup_valid_i  in  1  lookup_pc_i/lookup_inst_i are valid this cycle.
REQ-008 lookup_pc_i  in  ADDR_W  address of the instruction being fetched.
REQ-009 lookup_inst_i  in  32  instruction word at lookup_pc_i.
REQ-010 hold_i  in  1  pipeline stall; the lookup is not counted.
REQ-011 upd_valid_i  in  1  resolved conditional branch from EX this cycle.
REQ-012 upd_pc_i  in  ADDR_W  address of the resolved branch.
REQ-013 upd_taken_i  in  1  actual branch outcome.
REQ-014 upd_mispredict_i  in  1  the earlier prediction was wrong.
REQ-015 flush_i  in  1  interrupt/exception; invalidate all entries.
REQ-016 pred_taken_o  out  1  redirect fetch to pred_target_o.
REQ-017 pred_target_o  out  ADDR_W  predicted branch target.
REQ-018 pred_hit_o  out  1  lookup_pc_i matched a valid entry.
REQ-019 stat_lookups_o  out  32  count of counted B-type lookups.
REQ-020 stat_mispred_o  out  32  count of mispredicts.

Function
REQ-021 Each entry holds a valid bit, an ADDR_W tag and a CNT_W saturating counter.
REQ-022 Lookup is combinational with zero latency.
REQ-023 is_b = lookup_inst_i[6:0] equals the B-type opcode; imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, sign-extended to ADDR_W.
REQ-024 pred_target_o = lookup_pc_i + imm_b, modulo 2^ADDR_W, at all times.
REQ-025 pred_hit_o = lookup_valid_i & is_b & (some valid entry tag == lookup_pc_i).
REQ-026 On a hit, pred_taken_o = counter MSB of the matching entry.
REQ-027 On a miss with is_b, pred_taken_o = 0 for MISS_POLICY 0, or imm_b sign bit for MISS_POLICY 1.
REQ-028 When lookup_valid_i = 0 or is_b = 0, pred_taken_o = 0 and pred_hit_o = 0.
REQ-029 Update hit (upd_valid_i and tag == upd_pc_i): counter +1 if taken, else -1, saturating at 0 and at 2^CNT_W-1.
REQ-030 Update miss allocation:
- allocate the entry at the round-robin pointer rp
- valid = 1, tag = upd_pc_i
- counter = 2^(CNT_W-1) if taken, else 2^(CNT_W-1)-1
- rp increments, wrapping ENTRIES-1 -> 0.
REQ-031 Allocation happens only on a miss, so at most one entry matches any address.
REQ-032 Same-cycle lookup and update on the same PC: the lookup sees pre-update state; no bypass.
REQ-033 flush_i clears all valid bits and rp in the next cycle, and wins over a simultaneous update; tags and counters are don't-care.
REQ-034 stat_lookups_o increments when lookup_valid_i & is_b & !hold_i.
REQ-035 stat_mispred_o increments when upd_valid_i & upd_mispredict_i.
REQ-036 Both stat counters saturate at 32'hFFFF_FFFF and are unaffected by flush_i.

Reset
REQ-037 rst_n low asynchronously clears:
- all valid bits
- rp to 0
- counters to 2^(CNT_W-1)-1
- both stat counters to 0.
REQ-038 During and after reset, before any update: pred_hit_o = 0 and pred_taken_o follows MISS_POLICY.
REQ-039 Reset asserted mid-update discards the update; release is synchronised by the system reset logic.

Structure
REQ-040 The B-type opcode, counter init/threshold constants and MISS_POLICY encodings live in the shared define file.
REQ-041 One sub-module, bp_sat_cnt (CNT_W-wide up/down saturating counter with load), is instantiated per entry.
REQ-042 Match logic is a one-hot compare vector plus a binary encoder; no priority chain is needed (REQ-031).

Verification
REQ-043 Reset, then lookup pc=0x100 with a B-type imm=-8 and MISS_POLICY=1 -> pred_hit_o=0, pred_taken_o=1, pred_target_o=0xF8.
REQ-044 Update pc=0x100 taken, then the next-cycle lookup -> pred_hit_o=1, pred_taken_o=1 (counter=2); three not-taken updates -> counter 0, then saturates at 0; pred_taken_o=0.
REQ-045 ENTRIES=8: allocate 9 distinct PCs -> the 9th overwrites entry 0; a lookup of the first PC misses, a lookup of PC 2 hits.
REQ-046 Same-cycle flush_i and update miss -> no entry becomes valid, rp=0, stat counters unchanged.
REQ-047 hold_i=1 with a B-type lookup -> stat_lookups_o unchanged; preload stat_mispred_o near 32'hFFFF_FFFF, then two mispredicts -> holds at 32'hFFFF_FFFF.
